sprite_renderer: RTL and testbench

Consumer side of the sprite interface: takes the per-frame sprite rectangles written by the game logic and turns them into pixel colour for the VGA output stage. It latches the sprite set once per frame into shadow registers, so mid-frame position updates never tear. It hit-tests the current beam position against every sprite in a 2-stage pipeline. It delays sync/visible by the same latency so the colour stays aligned with the timing signals. It sits between the VGA timing generator and the RGB output pins.

---
 rtl/sprite_pkg.sv | 17 +
 rtl/vga_pkg.sv | 10 +
 rtl/sprite_if.sv | 10 +
 rtl/sprite_hit.sv | 20 ++
 rtl/sprite_renderer.sv | 113 +++++++++++
 tb/tb_sprite_renderer.sv | 167 ++++++++++++++++
 6 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg: the sprite rectangle type and the sprite slot indices.
// right and bottom are exclusive bounds.
package sprite_pkg;
  import vga_pkg::*;

  localparam int unsigned N_SPRITES  = 3;
  localparam int unsigned PLAYER_IDX = 0;
  localparam int unsigned ENEMY_IDX  = 1;
  localparam int unsigned BALL_IDX   = 2;

  typedef struct packed {
    logic [X_POS_W-1:0] x_pos;
    logic [Y_POS_W-1:0] y_pos;
    logic [X_POS_W-1:0] right;
    logic [Y_POS_W-1:0] bottom;
  } sprite_t;
endpackage

// File: rtl/vga_pkg.sv
// vga_pkg: display geometry and colour widths shared by the video path.
// RGB_W is 4 bits per channel. RGB_HALF is a mid-grey, one step above half
// scale on each channel.
package vga_pkg;
  localparam int unsigned RGB_W        = 12;
  localparam int unsigned X_POS_W      = 10;
  localparam int unsigned Y_POS_W      = 10;
  localparam int unsigned SCREEN_H_RES = 640;
  localparam logic [RGB_W-1:0] RGB_HALF = {3{4'h8}};
endpackage

// File: rtl/sprite_if.sv
// sprite_if: one sprite rectangle passed from the game logic to the renderer.
// Modports:
//   game_mp   - the producer drives sprite
//   render_mp - the consumer reads sprite
interface sprite_if;
  import sprite_pkg::*;
  sprite_t sprite;
  modport game_mp   (output sprite);
  modport render_mp (input  sprite);
endinterface

// File: rtl/sprite_hit.sv
// sprite_hit: combinational test of whether beam (i_x, i_y) lies inside one
// sprite rectangle.
// Ports:
//   i_spr - rectangle (x_pos, y_pos, right, bottom); right/bottom exclusive
//   i_x   - beam column
//   i_y   - beam line
//   o_hit - beam is inside the rectangle
// A zero-width or zero-height rectangle can never satisfy both bounds, so it
// never hits.
module sprite_hit
  import vga_pkg::*, sprite_pkg::*;
(
  input  sprite_t            i_spr,
  input  logic [X_POS_W-1:0] i_x,
  input  logic [Y_POS_W-1:0] i_y,
  output logic               o_hit
);
  assign o_hit = (i_x >= i_spr.x_pos) && (i_x < i_spr.right) &&
                 (i_y >= i_spr.y_pos) && (i_y < i_spr.bottom);
endmodule

// File: rtl/sprite_renderer.sv
// sprite_renderer: turns the per-frame sprite rectangles into pixel colour,
// using a 2-stage pipeline.
//   stage 1: per-sprite and net hit bits, plus visible/hsync/vsync
//   stage 2: priority mux into rgb_o, plus visible/hsync/vsync
// The sprite set is copied into shadow registers on new_frame_i. This keeps
// mid-frame updates by the game logic from tearing the picture.
// Priority, highest first: ball, player, enemy, net, background.
// Ports:
//   clk_i, rst_ni           - pixel clock; asynchronous active-low reset
//   new_frame_i             - start-of-vblank pulse; latches the sprite set
//   x_pos_i, y_pos_i        - beam position
//   visible_i, hsync_i, vsync_i  - timing from the VGA timing generator
//   sprites_i[N_SPRITES]    - sprite rectangles
//   rgb_o, visible_o, hsync_o, vsync_o - outputs, 2 cycles after the inputs
// Build option: define PONG_NET_EN to draw the dashed centre net.
module sprite_renderer
  import vga_pkg::*, sprite_pkg::*;
#(
  parameter logic [RGB_W-1:0] BG_COLOR      = '0,
  parameter logic [RGB_W-1:0] PADDLE_COLOR  = '1,
  parameter logic [RGB_W-1:0] BALL_COLOR    = '1,
  parameter logic [RGB_W-1:0] NET_COLOR     = RGB_HALF,
  parameter int unsigned      NET_DASH_LOG2 = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               new_frame_i,
  input  logic [X_POS_W-1:0] x_pos_i,
  input  logic [Y_POS_W-1:0] y_pos_i,
  input  logic               visible_i,
  input  logic               hsync_i,
  input  logic               vsync_i,
  sprite_if.render_mp        sprites_i [N_SPRITES],
  output logic [RGB_W-1:0]   rgb_o,
  output logic               visible_o,
  output logic               hsync_o,
  output logic               vsync_o
);
  sprite_t [N_SPRITES-1:0] w_spr;
  sprite_t [N_SPRITES-1:0] r_shadow;
  logic    [N_SPRITES-1:0] w_hit;
  logic                    w_net_hit;

  logic [N_SPRITES-1:0] r_s1_hit;
  logic                 r_s1_net;
  logic                 r_s1_vis, r_s1_hs, r_s1_vs;
  logic [RGB_W-1:0]     w_rgb;

  for (genvar g = 0; g < N_SPRITES; g++) begin : g_spr
    assign w_spr[g] = sprites_i[g].sprite;
    sprite_hit u_hit (
      .i_spr (r_shadow[g]),
      .i_x   (x_pos_i),
      .i_y   (y_pos_i),
      .o_hit (w_hit[g])
    );
  end

`ifdef PONG_NET_EN
  localparam logic [X_POS_W-1:0] NetColL = X_POS_W'(SCREEN_H_RES / 2 - 1);
  localparam logic [X_POS_W-1:0] NetColR = X_POS_W'(SCREEN_H_RES / 2);
  assign w_net_hit = ((x_pos_i == NetColL) || (x_pos_i == NetColR)) &&
                     !y_pos_i[NET_DASH_LOG2];
`else
  // The AND with 0 keeps NET_DASH_LOG2 referenced. It folds to a constant 0.
  assign w_net_hit = 1'b0 & ~y_pos_i[NET_DASH_LOG2];
`endif

  // Shadow set: the new set is used by the compare on the cycle after the pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)          r_shadow <= '0;
    else if (new_frame_i) r_shadow <= w_spr;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_hit <= '0;
      r_s1_net <= 1'b0;
      r_s1_vis <= 1'b0;
      r_s1_hs  <= 1'b0;
      r_s1_vs  <= 1'b0;
    end else begin
      r_s1_hit <= w_hit;
      r_s1_net <= w_net_hit;
      r_s1_vis <= visible_i;
      r_s1_hs  <= hsync_i;
      r_s1_vs  <= vsync_i;
    end
  end

  always_comb begin
    w_rgb = BG_COLOR;
    if (!r_s1_vis)                    w_rgb = '0;
    else if (r_s1_hit[BALL_IDX])      w_rgb = BALL_COLOR;
    else if (r_s1_hit[PLAYER_IDX])    w_rgb = PADDLE_COLOR;
    else if (r_s1_hit[ENEMY_IDX])     w_rgb = PADDLE_COLOR;
    else if (r_s1_net)                w_rgb = NET_COLOR;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rgb_o     <= '0;
      visible_o <= 1'b0;
      hsync_o   <= 1'b0;
      vsync_o   <= 1'b0;
    end else begin
      rgb_o     <= w_rgb;
      visible_o <= r_s1_vis;
      hsync_o   <= r_s1_hs;
      vsync_o   <= r_s1_vs;
    end
  end
endmodule

// File: tb/tb_sprite_renderer.sv
// tb_sprite_renderer: directed bench for sprite_renderer.
// The colours are overridden so that every priority level gives a distinct
// value. Each px() call drives one pixel together with its hand-computed
// colour. After the clock edge it checks the outputs of the pixel driven on
// the previous call, so every check lands 2 cycles after that pixel's inputs.
module tb_sprite_renderer;
  import vga_pkg::*;
  import sprite_pkg::*;

  localparam logic [RGB_W-1:0] BG  = 12'h00A;
  localparam logic [RGB_W-1:0] PAD = 12'h0F0;
  localparam logic [RGB_W-1:0] BAL = 12'hF00;
  localparam logic [RGB_W-1:0] NET = 12'h888;
`ifdef PONG_NET_EN
  localparam logic [RGB_W-1:0] NET_EXP = NET;
`else
  localparam logic [RGB_W-1:0] NET_EXP = BG;
`endif

  logic               clk = 1'b0;
  logic               rst_ni = 1'b0;
  logic               new_frame_i = 1'b0;
  logic [X_POS_W-1:0] x_pos_i = '0;
  logic [Y_POS_W-1:0] y_pos_i = '0;
  logic               visible_i = 1'b0, hsync_i = 1'b0, vsync_i = 1'b0;
  logic [RGB_W-1:0]   rgb_o;
  logic               visible_o, hsync_o, vsync_o;

  sprite_t [N_SPRITES-1:0] tb_spr = '0;
  sprite_if spr_if [N_SPRITES] ();
  for (genvar k = 0; k < N_SPRITES; k++) begin : g_drv
    assign spr_if[k].sprite = tb_spr[k];
  end

  sprite_renderer #(
    .BG_COLOR(BG), .PADDLE_COLOR(PAD), .BALL_COLOR(BAL),
    .NET_COLOR(NET), .NET_DASH_LOG2(3)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .new_frame_i(new_frame_i),
    .x_pos_i(x_pos_i), .y_pos_i(y_pos_i), .visible_i(visible_i),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .sprites_i(spr_if),
    .rgb_o(rgb_o), .visible_o(visible_o), .hsync_o(hsync_o), .vsync_o(vsync_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  logic             h_valid = 1'b0;
  string            p_tag;
  logic [RGB_W-1:0] p_rgb;
  logic             p_vis, p_hs, p_vs;

  function automatic sprite_t mk(input int x, input int y, input int r, input int b);
    sprite_t s;
    s.x_pos  = X_POS_W'(x);
    s.y_pos  = Y_POS_W'(y);
    s.right  = X_POS_W'(r);
    s.bottom = Y_POS_W'(b);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [RGB_W-1:0] act, input logic [RGB_W-1:0] exp);
    n_chk++;
    assert (act === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, act, exp);
  endtask

  // Drive one pixel, advance one cycle, then check the previous pixel.
  task automatic px(input string tag, input int x, input int y, input logic vis,
                    input logic hs, input logic vs, input logic nf,
                    input logic [RGB_W-1:0] exp);
    x_pos_i = X_POS_W'(x); y_pos_i = Y_POS_W'(y);
    visible_i = vis; hsync_i = hs; vsync_i = vs; new_frame_i = nf;
    @(posedge clk); #1;
    if (h_valid) begin
      chk({p_tag, ".rgb"}, rgb_o, p_rgb);
      chk({p_tag, ".vis"}, {11'b0, visible_o}, {11'b0, p_vis});
      chk({p_tag, ".hs"},  {11'b0, hsync_o},   {11'b0, p_hs});
      chk({p_tag, ".vs"},  {11'b0, vsync_o},   {11'b0, p_vs});
    end
    p_tag = tag; p_rgb = vis ? exp : '0;
    p_vis = vis; p_hs = hs; p_vs = vs; h_valid = 1'b1;
  endtask

  task automatic frame(); // new_frame_i pulse during blanking
    px("nf", 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, BG);
    px("post_nf", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, BG);
  endtask

  initial begin
    logic [2:0] pat [8];
    pat = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b111, 3'b011, 3'b101, 3'b110};

    // Reset held with an active visible beam
    x_pos_i = 10'd101; y_pos_i = 10'd50; visible_i = 1; hsync_i = 1; vsync_i = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.rgb", rgb_o, '0);
    chk("rst.vis", {11'b0, visible_o}, '0);
    chk("rst.hs",  {11'b0, hsync_o}, '0);
    chk("rst.vs",  {11'b0, vsync_o}, '0);
    tb_spr[BALL_IDX] = mk(100, 50, 104, 54);
    @(negedge clk) rst_ni = 1'b1;

    // No new_frame_i yet, so the shadow set is empty and only BG is drawn
    for (int y = 49; y <= 51; y++)
      for (int x = 98; x <= 105; x++) px("no_frame", x, y, 1, 0, 0, 0, BG);
    frame();

    // Ball edges on line 50, with the exclusive bottom edge checked on line 54
    for (int x = 96; x <= 108; x++)
      px("ball_edge", x, 50, 1, 0, 0, 0, (x >= 100 && x < 104) ? BAL : BG);
    px("ball_top", 101, 49, 1, 0, 0, 0, BG);
    px("ball_last", 101, 53, 1, 0, 0, 0, BAL);
    px("ball_bot", 101, 54, 1, 0, 0, 0, BG);
    frame();

    // Ball inside the player paddle; enemy elsewhere
    tb_spr[PLAYER_IDX] = mk(90, 40, 110, 70);
    tb_spr[ENEMY_IDX]  = mk(200, 40, 210, 70);
    frame();
    for (int x = 88; x <= 112; x++)
      px("overlap", x, 50, 1, 0, 0, 0,
         (x >= 100 && x < 104) ? BAL : (x >= 90 && x < 110) ? PAD : BG);
    px("enemy_in", 205, 50, 1, 0, 0, 0, PAD);
    px("enemy_out", 210, 50, 1, 0, 0, 0, BG);

    // Mid-frame move without new_frame_i keeps the old ball position
    tb_spr[BALL_IDX] = mk(300, 50, 304, 54);
    px("tear_old", 101, 50, 1, 0, 0, 0, BAL);
    px("tear_new", 301, 50, 1, 0, 0, 0, BG);
    frame();
    px("frm_old", 101, 50, 1, 0, 0, 0, PAD);
    px("frm_new", 301, 50, 1, 0, 0, 0, BAL);

    // Timing alignment: the {vis,hs,vs} pattern must reappear 2 cycles later
    for (int i = 0; i < 8; i++)
      px("align", 101, 50, pat[i][2], pat[i][1], pat[i][0], 0, PAD);

    // Centre net: dashes on lines 0..7, gaps on lines 8..15
    for (int y = 0; y < 16; y++)
      px("net", SCREEN_H_RES / 2, y, 1, 0, 0, 0, (y < 8) ? NET_EXP : BG);
    px("net_l", SCREEN_H_RES / 2 - 1, 2, 1, 0, 0, 0, NET_EXP);
    px("net_ll", SCREEN_H_RES / 2 - 2, 2, 1, 0, 0, 0, BG);
    px("net_rr", SCREEN_H_RES / 2 + 1, 2, 1, 0, 0, 0, BG);
    px("flush", 0, 0, 0, 0, 0, 0, BG);

    // Reset in the middle of a line clears the outputs immediately
    px("pre_rst", 101, 50, 1, 1, 0, 0, PAD);
    px("pre_rst", 101, 50, 1, 1, 0, 0, PAD);
    #2 rst_ni = 1'b0;
    #1;
    chk("midrst.rgb", rgb_o, '0);
    chk("midrst.vis", {11'b0, visible_o}, '0);
    chk("midrst.hs",  {11'b0, hsync_o}, '0);
    h_valid = 1'b0;
    @(negedge clk) rst_ni = 1'b1;
    // The shadow set was cleared, so the old paddle pixel is now BG
    px("post_rst", 101, 50, 1, 0, 0, 0, BG);
    px("post_rst", 301, 50, 1, 0, 0, 0, BG);
    px("flush", 0, 0, 0, 0, 0, 0, BG);
    px("flush", 0, 0, 0, 0, 0, 0, BG);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
